// File: rtl/sync_fifo_par.sv
// Single-clock FIFO with selectable FWFT/standard read, occupancy flags and per-byte even parity.
// Define SYNC_FIFO_PAR_PARITY_EN to store parity, drive parity_err and honour wr_par_inv.
module sync_fifo_par #(
    parameter int DATA_WIDTH          = 32,
    parameter int DEPTH_LOG2          = 9,
    parameter int ALMOST_FULL_OFFSET  = 128,
    parameter int ALMOST_EMPTY_OFFSET = 10,
    parameter int FWFT                = 1
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    full,
    output logic                    almost_full,
    output logic                    wr_err,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    empty,
    output logic                    almost_empty,
    output logic                    rd_err,
    output logic [DEPTH_LOG2:0]     count,
    output logic [DATA_WIDTH/8-1:0] parity_err,
    input  logic [DATA_WIDTH/8-1:0] wr_par_inv
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] L_DEPTH = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] L_AF    = (DEPTH_LOG2+1)'(DEPTH - ALMOST_FULL_OFFSET);
    localparam logic [DEPTH_LOG2:0] L_AE    = (DEPTH_LOG2+1)'(ALMOST_EMPTY_OFFSET);
    localparam logic [DEPTH_LOG2:0] L_ONE   = (DEPTH_LOG2+1)'(1);

`ifdef SYNC_FIFO_PAR_PARITY_EN
    localparam int SW = DATA_WIDTH + NB;

    function automatic logic [NB-1:0] f_bytepar(input logic [DATA_WIDTH-1:0] d);
        logic [NB-1:0] p;
        for (int b = 0; b < NB; b++) p[b] = ^d[8*b +: 8];
        return p;
    endfunction
`else
    localparam int SW = DATA_WIDTH;
`endif

    logic [SW-1:0]         r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_ovld;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [NB-1:0]         r_perr;
    logic                  r_full, r_afull, r_empty, r_aempty, r_wr_err, r_rd_err;

    logic [SW-1:0]         w_wr_word, w_rd_word;
    logic [DATA_WIDTH-1:0] w_rd_dat;
    logic [NB-1:0]         w_rd_perr;
    logic                  w_wr_acc, w_rd_acc, w_load, w_ovld_nxt, w_empty_nxt;
    logic [DEPTH_LOG2:0]   w_cnt_nxt, w_ram_cnt;

    assign w_rd_word = r_mem[r_rptr];

`ifdef SYNC_FIFO_PAR_PARITY_EN
    // Stored parity carries the injected inversion; the read side recomputes from data only.
    assign w_wr_word = {f_bytepar(wr_data) ^ wr_par_inv, wr_data};
    assign w_rd_dat  = w_rd_word[DATA_WIDTH-1:0];
    assign w_rd_perr = w_rd_word[SW-1:DATA_WIDTH] ^ f_bytepar(w_rd_dat);
`else
    logic w_unused;
    assign w_unused  = ^wr_par_inv;
    assign w_wr_word = wr_data;
    assign w_rd_dat  = w_rd_word;
    assign w_rd_perr = '0;
`endif

    assign w_wr_acc  = wr_en && !r_full;
    assign w_rd_acc  = rd_en && !r_empty;
    // Words sitting in RAM, excluding the FWFT output stage.
    assign w_ram_cnt = r_count - {{DEPTH_LOG2{1'b0}}, r_ovld};

    always_comb begin
        w_cnt_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_cnt_nxt = r_count + L_ONE;
            2'b01:   w_cnt_nxt = r_count - L_ONE;
            default: w_cnt_nxt = r_count;
        endcase
    end

    always_comb begin
        w_load      = 1'b0;
        w_ovld_nxt  = 1'b0;
        w_empty_nxt = 1'b1;
        if (FWFT != 0) begin
            w_load      = (!r_ovld || w_rd_acc) && (w_ram_cnt != '0);
            w_ovld_nxt  = w_load || (r_ovld && !w_rd_acc);
            w_empty_nxt = !w_ovld_nxt;
        end else begin
            w_load      = w_rd_acc;
            w_empty_nxt = (w_cnt_nxt == '0);
        end
    end

    always_ff @(posedge aclk) begin
        if (w_wr_acc) r_mem[r_wptr] <= w_wr_word;
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_ovld    <= 1'b0;
            r_rd_data <= '0;
            r_perr    <= '0;
            r_full    <= 1'b0;
            r_afull   <= 1'b0;
            r_empty   <= 1'b1;
            r_aempty  <= 1'b1;
            r_wr_err  <= 1'b0;
            r_rd_err  <= 1'b0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + DEPTH_LOG2'(1);
            if (w_load) begin
                r_rptr    <= r_rptr + DEPTH_LOG2'(1);
                r_rd_data <= w_rd_dat;
                r_perr    <= w_rd_perr;
            end
            r_count  <= w_cnt_nxt;
            r_ovld   <= w_ovld_nxt;
            r_full   <= (w_cnt_nxt == L_DEPTH);
            r_afull  <= (w_cnt_nxt >= L_AF);
            r_empty  <= w_empty_nxt;
            r_aempty <= (w_cnt_nxt <= L_AE);
            r_wr_err <= wr_en && r_full;
            r_rd_err <= rd_en && r_empty;
        end
    end

    assign full         = r_full;
    assign almost_full  = r_afull;
    assign wr_err       = r_wr_err;
    assign rd_data      = r_rd_data;
    assign empty        = r_empty;
    assign almost_empty = r_aempty;
    assign rd_err       = r_rd_err;
    assign count        = r_count;
    assign parity_err   = r_perr;
endmodule

// File: tb/tb_sync_fifo_par.sv
// Bench for sync_fifo_par: an FWFT and a standard-mode instance share stimulus and are
// compared every cycle against queue-based reference models.
module tb_sync_fifo_par;
    localparam int DEP = 16;

    logic        aclk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_par_inv = '0;

    logic        f_full, f_afull, f_werr, f_empty, f_aempty, f_rerr;
    logic [31:0] f_rdata;
    logic [4:0]  f_count;
    logic [3:0]  f_perr;
    logic        s_full, s_afull, s_werr, s_empty, s_aempty, s_rerr;
    logic [31:0] s_rdata;
    logic [4:0]  s_count;
    logic [3:0]  s_perr;

    int n_chk = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    sync_fifo_par #(.DATA_WIDTH(32), .DEPTH_LOG2(4), .ALMOST_FULL_OFFSET(4),
                    .ALMOST_EMPTY_OFFSET(2), .FWFT(1)) u_fwft (
        .aclk(aclk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(f_full),
        .almost_full(f_afull), .wr_err(f_werr), .rd_en(rd_en), .rd_data(f_rdata),
        .empty(f_empty), .almost_empty(f_aempty), .rd_err(f_rerr), .count(f_count),
        .parity_err(f_perr), .wr_par_inv(wr_par_inv));

    sync_fifo_par #(.DATA_WIDTH(32), .DEPTH_LOG2(4), .ALMOST_FULL_OFFSET(4),
                    .ALMOST_EMPTY_OFFSET(2), .FWFT(0)) u_std (
        .aclk(aclk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(s_full),
        .almost_full(s_afull), .wr_err(s_werr), .rd_en(rd_en), .rd_data(s_rdata),
        .empty(s_empty), .almost_empty(s_aempty), .rd_err(s_rerr), .count(s_count),
        .parity_err(s_perr), .wr_par_inv(wr_par_inv));

    typedef struct {
        logic [31:0] d;
        logic [3:0]  inv;
    } ent_t;

    ent_t        q1[$], q0[$];
    logic        ovld1;
    logic [31:0] rdat1, rdat0;
    logic [3:0]  perr1, perr0;
    logic        werr1, rerr1, werr0, rerr0;

    function automatic logic [3:0] exp_perr(input logic [3:0] inv);
`ifdef SYNC_FIFO_PAR_PARITY_EN
        return inv;
`else
        return 4'b0000 & inv;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q1.delete(); q0.delete();
        ovld1 = 1'b0;
        rdat1 = '0; rdat0 = '0; perr1 = '0; perr0 = '0;
        werr1 = 0; rerr1 = 0; werr0 = 0; rerr0 = 0;
    endtask

    // Applies the inputs that were present at the clock edge just taken.
    task automatic model_step();
        logic aw, ar, ld;
        int   ram_b;
        // FWFT: head word moves into the output stage one edge after it is available in storage.
        aw    = wr_en && (q1.size() < DEP);
        ar    = rd_en && ovld1;
        werr1 = wr_en && (q1.size() == DEP);
        rerr1 = rd_en && !ovld1;
        ram_b = q1.size() - (ovld1 ? 1 : 0);
        if (ar) void'(q1.pop_front());
        ld = (!ovld1 || ar) && (ram_b > 0);
        if (ld) begin
            rdat1 = q1[0].d;
            perr1 = exp_perr(q1[0].inv);
        end
        ovld1 = ld || (ovld1 && !ar);
        if (aw) q1.push_back('{d: wr_data, inv: wr_par_inv});
        // Standard mode.
        aw    = wr_en && (q0.size() < DEP);
        ar    = rd_en && (q0.size() > 0);
        werr0 = wr_en && (q0.size() == DEP);
        rerr0 = rd_en && (q0.size() == 0);
        if (ar) begin
            rdat0 = q0[0].d;
            perr0 = exp_perr(q0[0].inv);
            void'(q0.pop_front());
        end
        if (aw) q0.push_back('{d: wr_data, inv: wr_par_inv});
    endtask

    task automatic check_all();
        chk("f.count", f_count, q1.size());
        chk("f.empty", f_empty, !ovld1);
        chk("f.full", f_full, q1.size() == DEP);
        chk("f.almost_full", f_afull, q1.size() >= DEP - 4);
        chk("f.almost_empty", f_aempty, q1.size() <= 2);
        chk("f.wr_err", f_werr, werr1);
        chk("f.rd_err", f_rerr, rerr1);
        chk("f.rd_data", f_rdata, rdat1);
        chk("f.parity_err", f_perr, perr1);
        chk("s.count", s_count, q0.size());
        chk("s.empty", s_empty, q0.size() == 0);
        chk("s.full", s_full, q0.size() == DEP);
        chk("s.almost_full", s_afull, q0.size() >= DEP - 4);
        chk("s.almost_empty", s_aempty, q0.size() <= 2);
        chk("s.wr_err", s_werr, werr0);
        chk("s.rd_err", s_rerr, rerr0);
        chk("s.rd_data", s_rdata, rdat0);
        chk("s.parity_err", s_perr, perr0);
    endtask

    task automatic cycle();
        @(posedge aclk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic we, input logic [31:0] wd, input logic re,
                         input logic [3:0] inv);
        wr_en = we; wr_data = wd; rd_en = re; wr_par_inv = inv;
        cycle();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        check_all();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // Two-edge write-to-visible latency in FWFT mode.
        drive(1, 32'hA5A5_0001, 0, 0);
        chk("fwft_lat_empty_edge1", f_empty, 1'b1);
        chk("fwft_lat_count_edge1", f_count, 5'd1);
        drive(0, 0, 0, 0);
        chk("fwft_lat_empty_edge2", f_empty, 1'b0);
        chk("fwft_lat_data", f_rdata, 32'hA5A5_0001);
        drive(0, 0, 1, 0);
        chk("fwft_pop_empty", f_empty, 1'b1);
        chk("std_read_data", s_rdata, 32'hA5A5_0001);

        // Fill to full, overflow, drain with pointer wrap.
        for (int i = 0; i < 16; i++) drive(1, 32'(i), 0, 0);
        chk("fill_full", f_full, 1'b1);
        chk("fill_count", s_count, 5'd16);
        drive(1, 32'h99, 0, 0);
        chk("overflow_wr_err", s_werr, 1'b1);
        chk("overflow_count", f_count, 5'd16);
        for (int i = 0; i < 16; i++) drive(0, 0, 1, 0);
        chk("drain_last_std", s_rdata, 32'd15);
        drive(0, 0, 1, 0);
        chk("underflow_rd_err", s_rerr, 1'b1);
        chk("underflow_rd_hold", s_rdata, 32'd15);
        drive(0, 0, 0, 0);

        // Simultaneous read and write at count 5.
        for (int i = 0; i < 5; i++) drive(1, 32'(100 + i), 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 32'(200 + i), 1, 0);
        chk("simul_count", s_count, 5'd5);
        for (int i = 0; i < 7; i++) drive(0, 0, 1, 0);

        // Parity fault injection followed by a clean word.
        drive(1, 32'h1122_3344, 0, 4'b0100);
        drive(1, 32'h5566_7788, 0, 4'b0000);
        chk("par_word", f_rdata, 32'h1122_3344);
        chk("par_err", f_perr, exp_perr(4'b0100));
        drive(0, 0, 1, 0);
        chk("par_clean", f_perr, 4'b0000);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);

        // Randomised traffic: write-heavy, read-heavy, then balanced.
        for (int i = 0; i < 400; i++) begin
            wr_en      = $urandom_range(0, 99) < ((i < 130) ? 75 : (i < 260) ? 25 : 50);
            rd_en      = $urandom_range(0, 99) < ((i < 130) ? 25 : (i < 260) ? 75 : 50);
            wr_data    = $urandom;
            wr_par_inv = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            cycle();
        end
        for (int i = 0; i < 20; i++) drive(0, 0, 1, 0);

        // Reset in the middle of a burst.
        for (int i = 0; i < 7; i++) drive(1, 32'(300 + i), 0, 0);
        chk("pre_rst_count", f_count, 5'd7);
        wr_en = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_async_count", s_count, 5'd0);
        @(posedge aclk);
        #1;
        check_all();
        rst = 1'b0;
        drive(1, 32'hDEAD_BEEF, 0, 0);
        drive(0, 0, 0, 0);
        chk("post_rst_fwft", f_rdata, 32'hDEAD_BEEF);
        drive(0, 0, 1, 0);
        chk("post_rst_std", s_rdata, 32'hDEAD_BEEF);
        drive(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_par.md
Name: sync_fifo_par

Overview:
- Parametrised single-clock FIFO with per-byte even-parity generation and read-side checking.
- Successor to the fixed 512x36 primitive FIFO pair. Used on the AXI side of the eMMC/SERDES bridge where both ends share aclk.
- Adds configurable width and depth, selectable FWFT or standard read mode, occupancy count, programmable almost flags, and overflow/underflow error pulses.

Parameters:
- DATA_WIDTH, 32, payload width in bits; must be a multiple of 8; NB = DATA_WIDTH/8.
- DEPTH_LOG2, 9, log2 of FIFO capacity; DEPTH = 2**DEPTH_LOG2 words.
- ALMOST_FULL_OFFSET, 128, almost_full asserts when count >= DEPTH - ALMOST_FULL_OFFSET.
- ALMOST_EMPTY_OFFSET, 10, almost_empty asserts when count <= ALMOST_EMPTY_OFFSET.
- FWFT, 1, 1 = first-word-fall-through; 0 = standard read with 1-cycle latency.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write payload.
- full  out  1  count == DEPTH.
- almost_full  out  1  see parameter.
- wr_err  out  1  one-cycle pulse: write requested while full.
- rd_en  in  1  read request / pop.
- rd_data  out  DATA_WIDTH  read payload.
- empty  out  1  no word available to read.
- almost_empty  out  1  see parameter.
- rd_err  out  1  one-cycle pulse: read requested while empty.
- count  out  DEPTH_LOG2+1  words held, including any FWFT output stage.
- parity_err  out  NB  per-byte parity mismatch, aligned with rd_data (FIFO_PARITY_EN only, else tied 0).
- wr_par_inv  in  NB  test hook: inverts stored parity per byte (FIFO_PARITY_EN only).

Behaviour:
- Clocking and reset: one clock (aclk). Reset rst is asynchronous and active-high.
- Reset values:
  - empty = 1, almost_empty = 1.
  - full = 0, almost_full = 0.
  - count = 0, rd_data = 0.
  - wr_err = 0, rd_err = 0, parity_err = 0.
  - Pointers cleared; contents discarded.
  - Reset asserted mid-operation aborts everything; the first write after release behaves as a write to an empty FIFO.
- Storage: DEPTH entries of DATA_WIDTH (+NB parity bits when FIFO_PARITY_EN). Read and write pointers are DEPTH_LOG2 bits and wrap naturally from DEPTH-1 to 0.
- Write acceptance: write accepted iff wr_en && !full. If wr_en && full, the write is dropped and wr_err pulses on the next cycle. Full blocks writes even when a simultaneous read occurs.
- Read acceptance: read accepted iff rd_en && !empty. If rd_en && empty, rd_err pulses on the next cycle. A simultaneous write to an empty FIFO still proceeds.
- Count: registered. +1 on accepted write only, -1 on accepted read only, unchanged when both or neither occur. full, almost_full, empty (FWFT=0) and almost_empty are derived registered from the next count, so they are valid the cycle after the causing edge.
- FWFT=0:
  - empty = (count == 0).
  - rd_data updates on the edge after an accepted read; otherwise holds its value.
- FWFT=1:
  - An output register is prefetched from RAM whenever it is invalid and RAM holds data.
  - empty = !output_valid.
  - A word written into an empty FIFO appears on rd_data with empty low one edge after the write edge, giving a 2-edge write-to-visible latency.
  - rd_en pops the word; the next word is presented on the same edge if available.
- Parity: parity per byte is the XOR of that byte's bits, generated at write time. On read it is recomputed from stored data and compared; mismatch bits are presented with the corresponding rd_data.

Optional Feature:
- Macro: SYNC_FIFO_PAR_PARITY_EN.
- Defined: parity bits are stored, parity_err is active, and wr_par_inv XORs into the stored parity for fault injection.
- Undefined: no parity storage, parity_err is constant 0, and wr_par_inv is ignored. Storage width is DATA_WIDTH.

Test Plan:
Configuration for all scenarios: DATA_WIDTH=32, DEPTH_LOG2=4, ALMOST_FULL_OFFSET=4, ALMOST_EMPTY_OFFSET=2.
- Reset then idle -> empty=1, almost_empty=1, full=0, count=0, rd_data=0.
- FWFT=1, write 0xA5A5_0001 on one edge -> empty=0 after the following edge, rd_data=0xA5A5_0001, count=1; pulse rd_en -> empty=1, count=0.
- Write 16 words 0..15 -> almost_full once count=12, full at count=16; a 17th write -> wr_err pulse, count stays 16; read all 16 -> data 0..15 in order, pointers wrap cleanly.
- FWFT=0 on empty FIFO: rd_en -> rd_err pulse, rd_data unchanged. Simultaneous wr_en+rd_en at count=5 -> count stays 5, order preserved.
- With the macro defined, write 0x1122_3344 with wr_par_inv=4'b0100 -> read gives parity_err=4'b0100 with the matching word; the next clean word gives parity_err=0.
- Assert rst mid-burst at count=7 -> all outputs return to reset values immediately; after release, writing 0xDEAD_BEEF then reading returns 0xDEAD_BEEF.
